prefix_adder_16_bit_post_processing: RTL

- Sum-generation end of the 16-bit approximated parallel prefix adder.
- Consumes the per-bit propagate vector from the pre-processing stage and the group-generate (carry) vector from the prefix tree, and forms the 17-bit sum.
- Registered stage with valid/ready handshake and a 2-entry skid buffer, so the adder datapath can be pipelined and back-pressured.
- Optional approximation: carries into the low bits are ignored.

---
 rtl/prefix_adder_pkg.sv | 18 +
 rtl/prefix_adder_sum_gen.sv | 30 +++
 rtl/prefix_adder_16_bit_post_processing.sv | 93 +++++++++
 3 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared widths, sum type and carry-mask helper for the 16-bit prefix adder family.
package prefix_adder_pkg;

  localparam int ADDER_W = 16;
  localparam int SUM_W   = ADDER_W + 1;

  typedef logic [SUM_W-1:0] sum_t;

  // Bit i is 1 when the carry into sum bit i is kept; bits below n are dropped.
  function automatic logic [ADDER_W-1:0] carry_keep_mask(input int n);
    logic [ADDER_W-1:0] m;
    for (int i = 0; i < ADDER_W; i++) begin
      m[i] = (i >= n);
    end
    return m;
  endfunction

endpackage

// File: rtl/prefix_adder_sum_gen.sv
// Combinational sum formation from propagate and group-generate vectors,
// with optional suppression of carries into the low APPROX_LSBS bits.
module prefix_adder_sum_gen
  import prefix_adder_pkg::*;
#(
  parameter int APPROX_LSBS = 0
) (
  input  logic [ADDER_W-1:0] p,
  input  logic [SUM_W-1:0]   gp,
  output sum_t               sum
);

  if (APPROX_LSBS < 0 || APPROX_LSBS > ADDER_W - 1) begin : g_bad_approx
    $error("prefix_adder_sum_gen: APPROX_LSBS must be in 0..15");
  end

  localparam logic [ADDER_W-1:0] KEEP = carry_keep_mask(APPROX_LSBS);

  logic [ADDER_W-1:0] carry_in;
  // gp[15] duplicates the final carry already delivered on gp[16].
  logic               unused_gp_msb;

  assign unused_gp_msb = gp[ADDER_W-1];

  always_comb begin
    carry_in = {gp[ADDER_W-2:0], 1'b0} & KEEP;
    sum      = {gp[ADDER_W], p ^ carry_in};
  end

endmodule

// File: rtl/prefix_adder_16_bit_post_processing.sv
// Registered sum stage of the prefix adder: main output register plus one skid
// entry, so in_ready is a flop and never waits on out_ready combinationally.
module prefix_adder_16_bit_post_processing
  import prefix_adder_pkg::*;
#(
  parameter int APPROX_LSBS = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      p,
  input  logic [16:0]      gp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [16:0]      sum,
  output logic [CNT_W-1:0] out_count
);

  // Handshake: a beat moves on any rising edge where valid & ready are both 1;
  // a producer holding valid must keep its data stable until that edge.

  sum_t             sum_new;
  sum_t             main_q, main_d;
  logic             main_valid_q, main_valid_d;
  sum_t             skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             drain;

  prefix_adder_sum_gen #(
    .APPROX_LSBS(APPROX_LSBS)
  ) u_sum_gen (
    .p  (p),
    .gp (gp),
    .sum(sum_new)
  );

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    accept       = in_valid & ~skid_valid_q;
    drain        = main_valid_q & out_ready;

    if (!main_valid_q || drain) begin
      // Skid holds the older beat, so it must refill main before new input.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = sum_new;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = sum_new;
      skid_valid_d = 1'b1;
    end

    if (drain) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign sum       = main_q;
  assign out_count = cnt_q;

endmodule
